// File: rtl/adc_pkg.sv
// Shared SAR sequencer state encoding and default conversion parameters.
// The Controller bench picks up the DEF_* constants from here as well.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SAMPLE_CYCLES = 4;
    localparam int DEF_AVG_LOG2      = 0;

endpackage

// File: rtl/sar_core.sv
// One successive-approximation conversion: track for SAMPLE_CYCLES, then resolve one bit per cycle MSB first.
// The final code is presented combinationally on the last bit cycle so the caller can accumulate it on that edge.
module sar_core
    import adc_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic             comp,
    output logic             sample_hold,
    output logic [WIDTH-1:0] dac_code,
    output logic             conv_done,
    output logic [WIDTH-1:0] conv_code
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            phase;
    logic [3:0]        samp_cnt;
    logic [IW-1:0]     bit_idx;
    logic [WIDTH-1:0]  bit_mask;
    logic [WIDTH-1:0]  kept;

    // dac_code always holds the settled bits plus the trial bit, so no separate result register is needed
    always_comb begin
        bit_mask  = WIDTH'(1) << bit_idx;
        kept      = comp ? dac_code : (dac_code & ~bit_mask);
        conv_done = (phase == CONVERT) && (bit_idx == '0);
        conv_code = kept;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            phase       <= IDLE;
            samp_cnt    <= '0;
            bit_idx     <= '0;
            sample_hold <= 1'b0;
            dac_code    <= '0;
        end else begin
            case (phase)
                IDLE: begin
                    if (start) begin
                        phase       <= SAMPLE;
                        samp_cnt    <= '0;
                        sample_hold <= 1'b1;
                        dac_code    <= '0;
                    end
                end
                SAMPLE: begin
                    if (samp_cnt == 4'(SAMPLE_CYCLES - 1)) begin
                        phase       <= CONVERT;
                        bit_idx     <= IW'(WIDTH - 1);
                        sample_hold <= 1'b0;
                        dac_code    <= WIDTH'(1) << (WIDTH - 1);
                    end else begin
                        samp_cnt <= samp_cnt + 4'd1;
                    end
                end
                CONVERT: begin
                    if (bit_idx == '0) begin
                        // chained start skips IDLE so averaged conversions run back to back
                        phase       <= start ? SAMPLE : IDLE;
                        sample_hold <= start;
                        samp_cnt    <= '0;
                        dac_code    <= '0;
                    end else begin
                        bit_idx  <= bit_idx - IW'(1);
                        dac_code <= kept | (bit_mask >> 1);
                    end
                end
                default: phase <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/adc_sar_sequencer.sv
// SAR ADC sequencer top: owns IDLE/DONE, the averaging accumulator and the held ADC result.
// The sample/convert stepping of each individual conversion is delegated to sar_core.
module adc_sar_sequencer
    import adc_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int AVG_LOG2      = DEF_AVG_LOG2
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             Start,
    input  logic             Comp,
    output logic             Sample_Hold,
    output logic [WIDTH-1:0] DAC_Code,
    output logic             Busy,
    output logic [WIDTH-1:0] ADC,
    output logic             ADC_Valid
);

    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int CW    = AVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST_CONV = CW'((1 << AVG_LOG2) - 1);

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [CW-1:0]     avg_cnt;
    logic              core_start;
    logic              conv_done;
    logic [WIDTH-1:0]  conv_code;

    // While a run is in progress this FSM sits in CONVERT; the core tracks SAMPLE vs bit stepping itself
    assign core_start = ((state == IDLE) && Start) ||
                        ((state == CONVERT) && conv_done && (avg_cnt != LAST_CONV));

    sar_core #(
        .WIDTH         (WIDTH),
        .SAMPLE_CYCLES (SAMPLE_CYCLES)
    ) u_core (
        .CLK         (CLK),
        .rst         (rst),
        .start       (core_start),
        .comp        (Comp),
        .sample_hold (Sample_Hold),
        .dac_code    (DAC_Code),
        .conv_done   (conv_done),
        .conv_code   (conv_code)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            avg_cnt   <= '0;
            Busy      <= 1'b0;
            ADC       <= '0;
            ADC_Valid <= 1'b0;
        end else begin
            ADC_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= CONVERT;
                        acc     <= '0;
                        avg_cnt <= '0;
                        Busy    <= 1'b1;
                    end
                end
                CONVERT: begin
                    if (conv_done) begin
                        acc <= acc + ACC_W'(conv_code);
                        if (avg_cnt == LAST_CONV) state <= DONE;
                        else                      avg_cnt <= avg_cnt + CW'(1);
                    end
                end
                DONE: begin
                    ADC       <= WIDTH'(acc >> AVG_LOG2);
                    ADC_Valid <= 1'b1;
                    Busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Directed bench for adc_sar_sequencer: default instance for single conversions,
// a second instance with AVG_LOG2=2 for averaging. Comparator model is Comp = (Vin >= DAC_Code).
module tb_adc_sar_sequencer;

    logic       CLK = 1'b0;
    logic       rst;
    logic       Start, Comp, Sample_Hold, Busy, ADC_Valid;
    logic [7:0] DAC_Code, ADC, vin;

    logic       start_a, comp_a, sh_a, busy_a, valid_a;
    logic [7:0] dac_a, adc_a, vin_a;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign Comp   = (vin >= DAC_Code);
    assign comp_a = (vin_a >= dac_a);

    adc_sar_sequencer dut (
        .CLK(CLK), .rst(rst), .Start(Start), .Comp(Comp),
        .Sample_Hold(Sample_Hold), .DAC_Code(DAC_Code), .Busy(Busy),
        .ADC(ADC), .ADC_Valid(ADC_Valid)
    );

    adc_sar_sequencer #(.WIDTH(8), .SAMPLE_CYCLES(4), .AVG_LOG2(2)) dut_avg (
        .CLK(CLK), .rst(rst), .Start(start_a), .Comp(comp_a),
        .Sample_Hold(sh_a), .DAC_Code(dac_a), .Busy(busy_a),
        .ADC(adc_a), .ADC_Valid(valid_a)
    );

    typedef struct {
        logic [7:0] vin;
        logic [7:0] exp_adc;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] a5_steps[8];
    logic [7:0] steps[8];
    int         nsteps, sh_cycles, lat;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One conversion on the default instance; records latency, sample-hold cycles and DAC steps.
    task automatic convert(input logic [7:0] v);
        vin = v;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        lat = 0; sh_cycles = 0; nsteps = 0;
        while (!ADC_Valid && lat < 60) begin
            if (Sample_Hold) sh_cycles++;
            if (Busy && !Sample_Hold && DAC_Code != 8'h00 && nsteps < 8) begin
                steps[nsteps] = DAC_Code;
                nsteps++;
            end
            tick();
            lat++;
        end
        if (lat >= 60) chk("valid_timeout", 32'(lat), 32'd13);
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00};
        vecs[1] = '{8'hFF, 8'hFF};
        vecs[2] = '{8'hA5, 8'hA5};
        vecs[3] = '{8'h01, 8'h01};
        vecs[4] = '{8'h80, 8'h80};
        vecs[5] = '{8'h7F, 8'h7F};
        vecs[6] = '{8'h5A, 8'h5A};
        a5_steps = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        rst = 1'b1; Start = 1'b0; start_a = 1'b0; vin = 8'h00; vin_a = 8'h00;
        tick(); tick();
        chk("rst_adc", 32'(ADC), 32'h0);
        chk("rst_valid", 32'(ADC_Valid), 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_sh", 32'(Sample_Hold), 32'h0);
        chk("rst_dac", 32'(DAC_Code), 32'h0);
        chk("rst_avg_adc", 32'(adc_a), 32'h0);
        rst = 1'b0;
        tick();

        // Table-driven single conversions
        for (int i = 0; i < 7; i++) begin
            convert(vecs[i].vin);
            chk($sformatf("adc_%0h", vecs[i].vin), 32'(ADC), 32'(vecs[i].exp_adc));
            chk($sformatf("latency_%0h", vecs[i].vin), 32'(lat), 32'd13);
            chk($sformatf("sh_cycles_%0h", vecs[i].vin), 32'(sh_cycles), 32'd4);
            chk($sformatf("nsteps_%0h", vecs[i].vin), 32'(nsteps), 32'd8);
            if (vecs[i].vin == 8'hA5)
                for (int s = 0; s < 8; s++)
                    chk($sformatf("a5_step%0d", s), 32'(steps[s]), 32'(a5_steps[s]));
            tick();
            chk("valid_one_cycle", 32'(ADC_Valid), 32'h0);
            chk("adc_held", 32'(ADC), 32'(vecs[i].exp_adc));
        end

        // Reset during the bit-3 cycle, with a prior result of 0x5A held
        vin = 8'h3C;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("mid_bit3_dac", 32'(DAC_Code), 32'h38);
        chk("mid_prior_adc", 32'(ADC), 32'h5A);
        rst = 1'b1;
        tick();
        chk("midrst_adc", 32'(ADC), 32'h0);
        chk("midrst_busy", 32'(Busy), 32'h0);
        chk("midrst_dac", 32'(DAC_Code), 32'h0);
        chk("midrst_sh", 32'(Sample_Hold), 32'h0);
        rst = 1'b0;
        tick();
        convert(8'h3C);
        chk("post_rst_adc", 32'(ADC), 32'h3C);
        chk("post_rst_latency", 32'(lat), 32'd13);
        tick();

        // Start pulses while busy must be ignored
        begin
            int nvalid, vcyc;
            nvalid = 0; vcyc = 0;
            vin = 8'h33;
            Start = 1'b1;
            tick();
            Start = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                if (c == 5 || c == 9) Start = 1'b1;
                if (c == 6 || c == 10) Start = 1'b0;
                tick();
                if (ADC_Valid) begin
                    nvalid++;
                    vcyc = c;
                end
            end
            chk("busy_start_nvalid", 32'(nvalid), 32'd1);
            chk("busy_start_latency", 32'(vcyc), 32'd13);
            chk("busy_start_adc", 32'(ADC), 32'h33);
            chk("busy_start_idle", 32'(Busy), 32'h0);
        end

        // Averaging over four conversions on the AVG_LOG2=2 instance
        begin
            logic [7:0] avg_vin[4];
            logic       prev_sh;
            int         k, alat;
            avg_vin = '{8'h10, 8'h11, 8'h11, 8'h12};
            k = 0; alat = 0; prev_sh = 1'b0;
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            while (!valid_a && alat < 120) begin
                if (sh_a && !prev_sh) begin
                    if (k < 4) vin_a = avg_vin[k];
                    k++;
                end
                prev_sh = sh_a;
                tick();
                alat++;
            end
            chk("avg_latency", 32'(alat), 32'd49);
            chk("avg_adc", 32'(adc_a), 32'h11);
            chk("avg_sh_pulses", 32'(k), 32'd4);
            tick();
            chk("avg_busy_after", 32'(busy_a), 32'h0);
        end

        // Continuous sweep with Start held high
        begin
            logic [7:0] sw[31];
            int         k, cyc, last;
            for (int i = 0; i < 16; i++) sw[i] = 8'(i * 17);
            for (int i = 16; i < 31; i++) sw[i] = 8'((30 - i) * 17);
            k = 0; cyc = 0; last = -1;
            vin = sw[0];
            Start = 1'b1;
            while (k < 31 && cyc < 31 * 14 + 40) begin
                tick();
                cyc++;
                if (ADC_Valid) begin
                    chk($sformatf("sweep_adc%0d", k), 32'(ADC), 32'(sw[k]));
                    if (last < 0) chk("sweep_first", 32'(cyc), 32'd14);
                    else          chk($sformatf("sweep_period%0d", k), 32'(cyc - last), 32'd14);
                    last = cyc;
                    k++;
                    if (k == 31) Start = 1'b0;
                    else         vin = sw[k];
                end
            end
            Start = 1'b0;
            chk("sweep_count", 32'(k), 32'd31);
            for (int i = 0; i < 3; i++) tick();
            chk("sweep_idle", 32'(Busy), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_sar_sequencer.md
# adc_sar_sequencer

Digital successive-approximation sequencer that produces the 8-bit `ADC` code consumed by the oximeter `Controller`. It drives the front-end sample/hold switch and the 8-bit trim DAC, and reads back the analog comparator. It optionally averages 2^AVG_LOG2 conversions, then presents a held result with a one-cycle valid strobe. It sits between the analog comparator and the `Controller` `ADC[7:0]` input, clocked from the same `CLK`.

## Interface
- `WIDTH`, 8: conversion resolution in bits; `ADC`/`DAC_Code` width.
- `SAMPLE_CYCLES`, 4: cycles `Sample_Hold` stays high per conversion; legal range 1–15.
- `AVG_LOG2`, 0: log2 of the number of conversions averaged per result; legal range 0–4.

- `CLK` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `Start` input 1: request a result; sampled only in IDLE.
- `Comp` input 1: comparator output; 1 means Vin ≥ DAC voltage.
- `Sample_Hold` output 1: 1 = track input, 0 = hold.
- `DAC_Code` output WIDTH: trial code driven to the DAC.
- `Busy` output 1: high in every state except IDLE.
- `ADC` output WIDTH: last completed (averaged) result; held between results.
- `ADC_Valid` output 1: one-cycle strobe when `ADC` updates.

## Operation
- States: IDLE, SAMPLE, CONVERT, DONE.
- IDLE:
  - With `Start`=1 → SAMPLE; clear the accumulator and the average counter.
  - `Start` in any other state is ignored and not queued.
- SAMPLE:
  - `Sample_Hold`=1 and `DAC_Code`=0 for SAMPLE_CYCLES cycles.
  - Then → CONVERT with bit index = WIDTH-1 and trial result = 0.
- CONVERT, one bit per cycle, MSB first:
  - `DAC_Code` = result | (1<<i).
  - At the cycle end, `Comp`=1 keeps bit i; otherwise bit i is cleared.
  - After bit 0, add the result to the accumulator (WIDTH+AVG_LOG2 bits, no overflow possible).
  - If the average counter < 2^AVG_LOG2 − 1: increment it and go → SAMPLE.
  - Otherwise → DONE.
- DONE, single cycle:
  - `ADC` ← accumulator >> AVG_LOG2 (truncating).
  - `ADC_Valid`=1.
  - Then → IDLE.
- Holding `Start`=1 produces back-to-back results; IDLE lasts 1 cycle between them.
- `Comp` is treated as synchronous; a metastability synchroniser is external.

## Timing
- Reset values: state IDLE, `Sample_Hold`=0, `DAC_Code`=0, `Busy`=0, `ADC`=0, `ADC_Valid`=0, accumulator=0, counters=0.
- Reset mid-operation: all registers take reset values on the next edge. The partial result is discarded and `ADC` reads 0.
- Latency: with S = SAMPLE_CYCLES and N = 2^AVG_LOG2, `ADC_Valid` rises N·(S+WIDTH)+1 edges after the edge that samples `Start`.
  - Defaults give 13 edges.
- `ADC` changes only in the same cycle as `ADC_Valid` and is stable otherwise.
- `Busy` rises on the edge leaving IDLE and falls on the edge entering IDLE.
- `DAC_Code` returns to 0 in SAMPLE, DONE and IDLE.

## Structure
- Shared package `adc_pkg`:
  - state encoding localparams (IDLE, SAMPLE, CONVERT, DONE);
  - default WIDTH, SAMPLE_CYCLES and AVG_LOG2 constants, also used by the `Controller` bench.
- Sub-module `sar_core`:
  - handles one conversion: SAMPLE/CONVERT bit stepping;
  - outputs a `conv_done` pulse and `conv_code`.
- The top level owns IDLE/DONE, the accumulator, the average counter and the output registers.

## Test plan
- **Endpoint conversions.** Bench comparator model `Comp` = (Vin ≥ `DAC_Code`). Vin=0x00 → `ADC`=0x00; Vin=0xFF → `ADC`=0xFF. Each `ADC_Valid` arrives exactly 13 edges after `Start`.
- **Bit stepping.** Vin=0xA5 → `DAC_Code` steps 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5. Final `ADC`=0xA5; `Sample_Hold` is high for 4 cycles before the first step.
- **Averaging.** AVG_LOG2=2, Vin per conversion 0x10, 0x11, 0x11, 0x12. Result `ADC`=0x11 (accumulator 0x44); `ADC_Valid` at edge 4·12+1 = 49; `Sample_Hold` pulses 4 times.
- **Reset mid-conversion.** After a prior result of 0x5A, assert `rst` during the CONVERT cycle for bit 3. Next edge: `ADC`=0, `Busy`=0, `DAC_Code`=0. The next `Start` with Vin=0x3C yields 0x3C.
- **Start while busy.** Pulse `Start` while `Busy`=1 → no extra result and no state change.
- **Continuous sweep.** Hold `Start`=1 and sweep Vin 0x00→0xFF→0x00. One `ADC_Valid` every 14 cycles; each `ADC` equals the Vin present during its conversion.
